// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: registered bitwise logic unit with valid/ready handshakes.
// Single beats produce f_op(a,b) directly. In accumulate mode, a multi-beat
// packet is folded into one result using the op captured on the first beat.
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc_mode,
    input  logic             acc_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             red_and,
    output logic             red_or,
    output logic             red_xor,
    output logic [CNT_W-1:0] beat_cnt
);

    typedef enum logic {IDLE, ACC} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic [2:0]       op_q, op_q_nxt, op_eff;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc, emit_cnt;
    logic [WIDTH-1:0] r, fold, emit_y;
    logic             accept, emit;

    function automatic logic [WIDTH-1:0] f_op(input logic [2:0] sel,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] z);
        logic [WIDTH-1:0] res;
        case (sel)
            3'b000:  res = x & z;
            3'b001:  res = x | z;
            3'b010:  res = ~(x & z);
            3'b011:  res = ~(x | z);
            3'b100:  res = x ^ z;
            3'b101:  res = ~(x ^ z);
            3'b110:  res = ~x;
            default: res = x;
        endcase
        return res;
    endfunction

    // A new beat is only taken when the output register is free or draining.
    assign in_ready = !rst && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Inside a packet the captured op governs every beat.
    assign op_eff  = (state == ACC) ? op_q : op;
    assign r       = f_op(op_eff, a, b);
    // NOT/PASS are unary, so folding them just keeps the newest beat result.
    assign fold    = (op_q[2:1] == 2'b11) ? r : f_op(op_q, acc, r);
    assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

    // Next-state logic: decides whether a beat starts, extends or closes a packet.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        op_q_nxt  = op_q;
        cnt_nxt   = cnt;
        emit      = 1'b0;
        emit_y    = r;
        emit_cnt  = CNT_W'(1);
        case (state)
            IDLE: begin
                if (accept) begin
                    if (acc_mode && !acc_last) begin
                        acc_nxt   = r;
                        op_q_nxt  = op;
                        cnt_nxt   = CNT_W'(1);
                        state_nxt = ACC;
                    end else begin
                        emit = 1'b1;
                    end
                end
            end
            ACC: begin
                if (accept) begin
                    cnt_nxt = cnt_inc;
                    if (acc_last) begin
                        emit      = 1'b1;
                        emit_y    = fold;
                        emit_cnt  = cnt_inc;
                        state_nxt = IDLE;
                    end else begin
                        acc_nxt = fold;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Packet state registers; reset drops any half-built packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            op_q  <= 3'b000;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            op_q  <= op_q_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Output register: loads on emit, holds while stalled, clears once drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
            red_and   <= 1'b0;
            red_or    <= 1'b0;
            red_xor   <= 1'b0;
            beat_cnt  <= '0;
        end else if (emit) begin
            out_valid <= 1'b1;
            y         <= emit_y;
            red_and   <= &emit_y;
            red_or    <= |emit_y;
            red_xor   <= ^emit_y;
            beat_cnt  <= emit_cnt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
